// File: rtl/alu_flag_reg_if.sv
// Status-unit bus: ALU op/operand/result inputs toward the flag register and registered NZCV outputs back.
// master = ALU side / driver, slave = alu_flag_reg.
interface alu_flag_reg_if #(
  parameter int W     = 4,
  parameter int OPW   = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [OPW-1:0]   opcode;
  logic [W-1:0]     operand_a;
  logic [W-1:0]     operand_b;
  logic [W-1:0]     op_result;
  logic             add_cout;
  logic             sub_cout;
  logic             clr_cnt;
  logic             out_valid;
  logic             negative;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic [CNT_W-1:0] ovf_count;
  logic             sticky_ovf;
  logic             sticky_c;

  modport master (
    output in_valid, opcode, operand_a, operand_b, op_result, add_cout, sub_cout, clr_cnt,
    input  out_valid, negative, zero, cout, overflow, ovf_count, sticky_ovf, sticky_c
  );

  modport slave (
    input  in_valid, opcode, operand_a, operand_b, op_result, add_cout, sub_cout, clr_cnt,
    output out_valid, negative, zero, cout, overflow, ovf_count, sticky_ovf, sticky_c
  );
endinterface

// File: rtl/alu_flag_reg.sv
// Registered NZCV status unit with saturating overflow-event counter.
// Optional sticky V/C bits are built only when ALU_STICKY_FLAGS_EN is defined.
package alu_ops;
  localparam logic [3:0] ADD_OP = 4'h0;
  localparam logic [3:0] SUB_OP = 4'h1;
  localparam logic [3:0] AND_OP = 4'h2;
  localparam logic [3:0] OR_OP  = 4'h3;
  localparam logic [3:0] XOR_OP = 4'h4;
endpackage

module alu_flag_reg
  import alu_ops::*;
#(
  parameter int W     = 4,
  parameter int OPW   = 4,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_flag_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             out_valid_q, out_valid_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_add, is_sub, is_arith;
  logic a_msb, b_msb, r_msb;
  logic v_new, c_new;

  always_comb begin
    is_add   = bus.in_valid && (bus.opcode == OPW'(ADD_OP));
    is_sub   = bus.in_valid && (bus.opcode == OPW'(SUB_OP));
    is_arith = is_add || is_sub;
    a_msb    = bus.operand_a[W-1];
    b_msb    = bus.operand_b[W-1];
    r_msb    = bus.op_result[W-1];
    // Two's-complement overflow: sign of the result disagrees with A when the operation cannot legally flip it.
    v_new    = 1'b0;
    c_new    = 1'b0;
    if (is_add) begin
      v_new = (a_msb == b_msb) && (r_msb != a_msb);
      c_new = bus.add_cout;
    end else if (is_sub) begin
      v_new = (a_msb != b_msb) && (r_msb != a_msb);
      c_new = bus.sub_cout;
    end

    out_valid_d = bus.in_valid;
    neg_d       = neg_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (bus.in_valid) begin
      neg_d  = r_msb;
      zero_d = (bus.op_result == '0);
    end
    if (is_arith) begin
      cout_d = c_new;
      ovf_d  = v_new;
    end

    cnt_d = bus.clr_cnt ? '0 : cnt_q;
    if (is_arith && v_new) begin
      if (bus.clr_cnt)          cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_ovf_q, sticky_ovf_d;
  logic sticky_c_q, sticky_c_d;

  // A set on the same edge as clr_cnt wins over the clear.
  always_comb begin
    sticky_ovf_d = (bus.clr_cnt ? 1'b0 : sticky_ovf_q) | (is_arith & v_new);
    sticky_c_d   = (bus.clr_cnt ? 1'b0 : sticky_c_q)   | (is_arith & c_new);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf_q <= 1'b0;
      sticky_c_q   <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_c_q   <= sticky_c_d;
    end
  end

  assign bus.sticky_ovf = sticky_ovf_q;
  assign bus.sticky_c   = sticky_c_q;
`else
  assign bus.sticky_ovf = 1'b0;
  assign bus.sticky_c   = 1'b0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.ovf_count = cnt_q;

endmodule

// File: tb/tb_alu_flag_reg.sv
// Directed-vector bench for alu_flag_reg at W=4, CNT_W=2; sticky expectations follow ALU_STICKY_FLAGS_EN.
module tb_alu_flag_reg;
  import alu_ops::*;

`ifdef ALU_STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam logic [3:0] OTHER_OP = 4'hF;

  logic clk = 1'b0;
  logic rst;

  alu_flag_reg_if #(.W(4), .OPW(4), .CNT_W(2)) bus ();

  alu_flag_reg #(.W(4), .OPW(4), .CNT_W(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, vld;
    logic [3:0] op, a, b, res;
    logic       acout, scout, clr;
    logic       e_ov, e_n, e_z, e_c, e_v;
    logic [1:0] e_cnt;
    logic       e_so, e_sc;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[17];

  function automatic vec_t mk(
    input logic r, input logic v, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
    input logic [3:0] res, input logic ac, input logic sc, input logic clr,
    input logic ov, input logic n, input logic z, input logic c, input logic vv,
    input logic [1:0] cnt, input logic so, input logic stc);
    vec_t t;
    t.rst = r; t.vld = v; t.op = op; t.a = a; t.b = b; t.res = res;
    t.acout = ac; t.scout = sc; t.clr = clr;
    t.e_ov = ov; t.e_n = n; t.e_z = z; t.e_c = c; t.e_v = vv;
    t.e_cnt = cnt; t.e_so = so; t.e_sc = stc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    rst           = t.rst;
    bus.in_valid  = t.vld;
    bus.opcode    = t.op;
    bus.operand_a = t.a;
    bus.operand_b = t.b;
    bus.op_result = t.res;
    bus.add_cout  = t.acout;
    bus.sub_cout  = t.scout;
    bus.clr_cnt   = t.clr;
  endtask

  task automatic check_all(input string tag, input vec_t t);
    chk({tag, ".out_valid"}, {3'b0, bus.out_valid}, {3'b0, t.e_ov});
    chk({tag, ".N"}, {3'b0, bus.negative}, {3'b0, t.e_n});
    chk({tag, ".Z"}, {3'b0, bus.zero}, {3'b0, t.e_z});
    chk({tag, ".C"}, {3'b0, bus.cout}, {3'b0, t.e_c});
    chk({tag, ".V"}, {3'b0, bus.overflow}, {3'b0, t.e_v});
    chk({tag, ".ovf_count"}, {2'b0, bus.ovf_count}, {2'b0, t.e_cnt});
    chk({tag, ".sticky_ovf"}, {3'b0, bus.sticky_ovf}, {3'b0, STICKY & t.e_so});
    chk({tag, ".sticky_c"}, {3'b0, bus.sticky_c}, {3'b0, STICKY & t.e_sc});
  endtask

  task automatic step(input string tag, input vec_t t);
    drive(t);
    @(posedge clk);
    #1;
    check_all(tag, t);
  endtask

  initial begin
    //                rst vld op        a   b   res ac sc clr | ov n  z  c  v  cnt so sc
    tbl[0]  = mk(1, 1, ADD_OP,   7,  1,  8, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, ADD_OP,   0,  0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, ADD_OP,   7,  1,  8, 0, 0, 0,  1, 1, 0, 0, 1, 1, 1, 0);
    tbl[3]  = mk(0, 1, SUB_OP,   5,  5,  0, 0, 1, 0,  1, 0, 1, 1, 0, 1, 1, 1);
    tbl[4]  = mk(0, 1, SUB_OP,   8,  1,  7, 0, 1, 0,  1, 0, 0, 1, 1, 2, 1, 1);
    tbl[5]  = mk(0, 1, ADD_OP,   4,  4,  8, 0, 0, 0,  1, 1, 0, 0, 1, 3, 1, 1);
    tbl[6]  = mk(0, 1, AND_OP,   4,  3,  0, 1, 1, 0,  1, 0, 1, 0, 1, 3, 1, 1);
    tbl[7]  = mk(0, 0, ADD_OP,   7,  1,  5, 1, 1, 0,  0, 0, 1, 0, 1, 3, 1, 1);
    tbl[8]  = mk(0, 0, SUB_OP,   8,  1,  9, 1, 1, 0,  0, 0, 1, 0, 1, 3, 1, 1);
    tbl[9]  = mk(0, 1, ADD_OP,   7,  1,  8, 0, 0, 0,  1, 1, 0, 0, 1, 3, 1, 1);
    tbl[10] = mk(0, 0, ADD_OP,   0,  0,  0, 0, 0, 1,  0, 1, 0, 0, 1, 0, 0, 0);
    tbl[11] = mk(0, 1, ADD_OP,  15, 15, 14, 1, 0, 0,  1, 1, 0, 1, 0, 0, 0, 1);
    tbl[12] = mk(0, 1, OTHER_OP, 1,  2,  3, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 1);
    tbl[13] = mk(0, 1, ADD_OP,   7,  1,  8, 0, 0, 1,  1, 1, 0, 0, 1, 1, 1, 0);
    tbl[14] = mk(0, 1, ADD_OP,   7,  1,  8, 0, 0, 0,  1, 1, 0, 0, 1, 2, 1, 0);
    tbl[15] = mk(1, 1, ADD_OP,   7,  1,  8, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 1, SUB_OP,   0,  1, 15, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Saturation: five overflowing ADDs back-to-back after a clear.
    step("clr_idle", mk(0, 0, ADD_OP, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      logic [1:0] ec;
      ec = (k < 3) ? 2'(k + 1) : 2'd3;
      step($sformatf("sat%0d", k), mk(0, 1, ADD_OP, 7, 1, 8, 0, 0, 0, 1, 1, 0, 0, 1, ec, 1, 0));
    end

    // Sticky V survives a non-overflowing ADD, then clr_cnt drops it.
    step("add_1p1", mk(0, 1, ADD_OP, 1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 3, 1, 0));
    step("clr_sticky", mk(0, 0, ADD_OP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step("clr_vs_ovf", mk(0, 1, ADD_OP, 7, 1, 8, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0));
    step("rst_inflight", mk(1, 1, SUB_OP, 8, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("after_rst_idle", mk(0, 0, ADD_OP, 7, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
